debug_ram_ctrl: RTL and testbench

Request front-end for the debug RAM. It arbitrates between the debug-module (DMI) register-access path and the hart's debug-mode load/store/fetch path. It drives the debug RAM's cs/wr_en/addr/wdat port, captures its one-cycle registered read data, and returns buffered responses with valid/ready handshakes. Only one transaction is outstanding at a time, and requesters are served round-robin on conflict.

---
 rtl/debug_ram_pkg.sv | 26 ++
 rtl/debug_ram_arb.sv | 37 +++
 rtl/debug_ram_ctrl.sv | 179 +++++++++++++++++
 tb/tb_debug_ram_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_ram_pkg.sv
// Shared types for the debug RAM request front-end: FSM states, requester IDs
// and the muxed request payload.
package debug_ram_pkg;

    // Wide enough for any supported SRAM_DEPTH_LOG; narrower addresses are zero-extended.
    localparam int unsigned DRAM_MAX_AW = 16;
    localparam int unsigned DRAM_DW     = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RSP     = 2'd2
    } dram_state_e;

    typedef enum logic {
        SRC_DMI  = 1'b0,
        SRC_CORE = 1'b1
    } dram_src_e;

    typedef struct packed {
        logic                   write;
        logic [DRAM_MAX_AW-1:0] addr;
        logic [DRAM_DW-1:0]     wdata;
    } dram_req_t;

endpackage

// File: rtl/debug_ram_arb.sv
// Two-way round-robin arbiter between DMI (bit 0) and core (bit 1) requesters.
module debug_ram_arb
    import debug_ram_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    input  logic       accept,
    output logic [1:0] grant
);

    dram_src_e last_grant_q, last_grant_d;

    // On conflict favour the requester that was not served last.
    always_comb begin
        grant = valid;
        if (valid == 2'b11) begin
            grant = (last_grant_q == SRC_DMI) ? 2'b10 : 2'b01;
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (accept) begin
            last_grant_d = grant[1] ? SRC_CORE : SRC_DMI;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= SRC_DMI;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/debug_ram_ctrl.sv
// Debug RAM request front-end: arbitrates DMI and hart requests, drives the RAM
// port and returns buffered responses, one transaction outstanding at a time.
module debug_ram_ctrl
    import debug_ram_pkg::*;
#(
    parameter int unsigned SRAM_DEPTH     = 16,
    parameter int unsigned SRAM_DEPTH_LOG = $clog2(SRAM_DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst_n,

    input  logic                      dmi_req_valid,
    output logic                      dmi_req_ready,
    input  logic                      dmi_req_write,
    input  logic [SRAM_DEPTH_LOG-1:0] dmi_req_addr,
    input  logic [31:0]               dmi_req_wdata,
    output logic                      dmi_rsp_valid,
    input  logic                      dmi_rsp_ready,
    output logic [31:0]               dmi_rsp_rdata,
    output logic                      dmi_rsp_err,

    input  logic                      core_req_valid,
    output logic                      core_req_ready,
    input  logic                      core_req_write,
    input  logic [SRAM_DEPTH_LOG-1:0] core_req_addr,
    input  logic [31:0]               core_req_wdata,
    output logic                      core_rsp_valid,
    output logic [31:0]               core_rsp_rdata,
    output logic                      core_rsp_err,

    output logic                      ram_cs,
    output logic                      ram_wr_en,
    output logic [SRAM_DEPTH_LOG-1:0] ram_addr,
    output logic [31:0]               ram_wdat,
    input  logic [31:0]               ram_dout
);

    dram_state_e state_q, state_d;
    dram_src_e   owner_q, owner_d;

    logic        dmi_rsp_valid_q, dmi_rsp_valid_d;
    logic [31:0] dmi_rsp_rdata_q, dmi_rsp_rdata_d;
    logic        dmi_rsp_err_q, dmi_rsp_err_d;
    logic        core_rsp_valid_q, core_rsp_valid_d;
    logic [31:0] core_rsp_rdata_q, core_rsp_rdata_d;
    logic        core_rsp_err_q, core_rsp_err_d;

    logic [1:0]  req_valid, grant;
    logic        idle_c, accept_c, in_range_c;
    dram_req_t   req_sel;
    dram_src_e   grant_src;

    logic        rsp_load;
    dram_src_e   rsp_src;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    assign req_valid = {core_req_valid, dmi_req_valid};

    debug_ram_arb u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .valid  (req_valid),
        .accept (accept_c),
        .grant  (grant)
    );

    // Readiness is forced low while reset is asserted, not only after it.
    assign idle_c         = (state_q == IDLE) && rst_n;
    assign dmi_req_ready  = idle_c && grant[0];
    assign core_req_ready = idle_c && grant[1];
    assign accept_c       = (dmi_req_valid && dmi_req_ready) || (core_req_valid && core_req_ready);
    assign grant_src      = grant[1] ? SRC_CORE : SRC_DMI;

    always_comb begin
        if (grant[1]) begin
            req_sel = '{write: core_req_write, addr: DRAM_MAX_AW'(core_req_addr), wdata: core_req_wdata};
        end else begin
            req_sel = '{write: dmi_req_write, addr: DRAM_MAX_AW'(dmi_req_addr), wdata: dmi_req_wdata};
        end
    end

    assign in_range_c = 32'(req_sel.addr) < 32'(SRAM_DEPTH);

    assign ram_cs    = accept_c && in_range_c;
    assign ram_wr_en = accept_c && req_sel.write;
    assign ram_addr  = accept_c ? SRAM_DEPTH_LOG'(req_sel.addr) : '0;
    assign ram_wdat  = accept_c ? req_sel.wdata : '0;

    // Next state plus response-buffer loading; core responses self-clear after one cycle.
    always_comb begin
        state_d          = state_q;
        owner_d          = owner_q;
        dmi_rsp_valid_d  = dmi_rsp_valid_q;
        dmi_rsp_rdata_d  = dmi_rsp_rdata_q;
        dmi_rsp_err_d    = dmi_rsp_err_q;
        core_rsp_valid_d = 1'b0;
        core_rsp_rdata_d = '0;
        core_rsp_err_d   = 1'b0;
        rsp_load         = 1'b0;
        rsp_src          = owner_q;
        rsp_rdata        = '0;
        rsp_err          = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    owner_d = grant_src;
                    if (!req_sel.write && in_range_c) begin
                        state_d = RD_WAIT;
                    end else begin
                        state_d  = RSP;
                        rsp_load = 1'b1;
                        rsp_src  = grant_src;
                        rsp_err  = !in_range_c;
                    end
                end
            end
            RD_WAIT: begin
                state_d   = RSP;
                rsp_load  = 1'b1;
                rsp_rdata = ram_dout;
            end
            RSP: begin
                if (owner_q == SRC_CORE) begin
                    state_d = IDLE;
                end else if (dmi_rsp_ready) begin
                    state_d         = IDLE;
                    dmi_rsp_valid_d = 1'b0;
                    dmi_rsp_rdata_d = '0;
                    dmi_rsp_err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (rsp_load) begin
            if (rsp_src == SRC_CORE) begin
                core_rsp_valid_d = 1'b1;
                core_rsp_rdata_d = rsp_rdata;
                core_rsp_err_d   = rsp_err;
            end else begin
                dmi_rsp_valid_d = 1'b1;
                dmi_rsp_rdata_d = rsp_rdata;
                dmi_rsp_err_d   = rsp_err;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            owner_q          <= SRC_DMI;
            dmi_rsp_valid_q  <= 1'b0;
            dmi_rsp_rdata_q  <= '0;
            dmi_rsp_err_q    <= 1'b0;
            core_rsp_valid_q <= 1'b0;
            core_rsp_rdata_q <= '0;
            core_rsp_err_q   <= 1'b0;
        end else begin
            state_q          <= state_d;
            owner_q          <= owner_d;
            dmi_rsp_valid_q  <= dmi_rsp_valid_d;
            dmi_rsp_rdata_q  <= dmi_rsp_rdata_d;
            dmi_rsp_err_q    <= dmi_rsp_err_d;
            core_rsp_valid_q <= core_rsp_valid_d;
            core_rsp_rdata_q <= core_rsp_rdata_d;
            core_rsp_err_q   <= core_rsp_err_d;
        end
    end

    assign dmi_rsp_valid  = dmi_rsp_valid_q;
    assign dmi_rsp_rdata  = dmi_rsp_rdata_q;
    assign dmi_rsp_err    = dmi_rsp_err_q;
    assign core_rsp_valid = core_rsp_valid_q;
    assign core_rsp_rdata = core_rsp_rdata_q;
    assign core_rsp_err   = core_rsp_err_q;

endmodule

// File: tb/tb_debug_ram_ctrl.sv
// Directed bench for debug_ram_ctrl: a 16-deep instance on a behavioural RAM and a
// 12-deep instance sharing the same request inputs for the out-of-range case.
module tb_debug_ram_ctrl;

    logic        clk;
    logic        rst_n;

    logic        dmi_req_valid, dmi_req_write, dmi_rsp_ready;
    logic [3:0]  dmi_req_addr;
    logic [31:0] dmi_req_wdata;
    logic        core_req_valid, core_req_write;
    logic [3:0]  core_req_addr;
    logic [31:0] core_req_wdata;

    logic        dmi_req_ready, dmi_rsp_valid, dmi_rsp_err;
    logic [31:0] dmi_rsp_rdata;
    logic        core_req_ready, core_rsp_valid, core_rsp_err;
    logic [31:0] core_rsp_rdata;
    logic        ram_cs, ram_wr_en;
    logic [3:0]  ram_addr;
    logic [31:0] ram_wdat, ram_dout;

    logic        dmi_req_ready_b, dmi_rsp_valid_b, dmi_rsp_err_b;
    logic [31:0] dmi_rsp_rdata_b;
    logic        core_req_ready_b, core_rsp_valid_b, core_rsp_err_b;
    logic [31:0] core_rsp_rdata_b;
    logic        ram_cs_b, ram_wr_en_b;
    logic [3:0]  ram_addr_b;
    logic [31:0] ram_wdat_b;
    logic [31:0] ram_dout_b;

    logic [31:0] mem [16];

    int n_chk;
    int n_fail;

    debug_ram_ctrl #(.SRAM_DEPTH(16)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .dmi_req_valid(dmi_req_valid), .dmi_req_ready(dmi_req_ready),
        .dmi_req_write(dmi_req_write), .dmi_req_addr(dmi_req_addr), .dmi_req_wdata(dmi_req_wdata),
        .dmi_rsp_valid(dmi_rsp_valid), .dmi_rsp_ready(dmi_rsp_ready),
        .dmi_rsp_rdata(dmi_rsp_rdata), .dmi_rsp_err(dmi_rsp_err),
        .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
        .core_req_write(core_req_write), .core_req_addr(core_req_addr), .core_req_wdata(core_req_wdata),
        .core_rsp_valid(core_rsp_valid), .core_rsp_rdata(core_rsp_rdata), .core_rsp_err(core_rsp_err),
        .ram_cs(ram_cs), .ram_wr_en(ram_wr_en), .ram_addr(ram_addr), .ram_wdat(ram_wdat),
        .ram_dout(ram_dout)
    );

    debug_ram_ctrl #(.SRAM_DEPTH(12)) u_dut12 (
        .clk(clk), .rst_n(rst_n),
        .dmi_req_valid(dmi_req_valid), .dmi_req_ready(dmi_req_ready_b),
        .dmi_req_write(dmi_req_write), .dmi_req_addr(dmi_req_addr), .dmi_req_wdata(dmi_req_wdata),
        .dmi_rsp_valid(dmi_rsp_valid_b), .dmi_rsp_ready(dmi_rsp_ready),
        .dmi_rsp_rdata(dmi_rsp_rdata_b), .dmi_rsp_err(dmi_rsp_err_b),
        .core_req_valid(core_req_valid), .core_req_ready(core_req_ready_b),
        .core_req_write(core_req_write), .core_req_addr(core_req_addr), .core_req_wdata(core_req_wdata),
        .core_rsp_valid(core_rsp_valid_b), .core_rsp_rdata(core_rsp_rdata_b), .core_rsp_err(core_rsp_err_b),
        .ram_cs(ram_cs_b), .ram_wr_en(ram_wr_en_b), .ram_addr(ram_addr_b), .ram_wdat(ram_wdat_b),
        .ram_dout(ram_dout_b)
    );

    assign ram_dout_b = 32'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural debug RAM with one-cycle registered read data; contents survive reset.
    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_wr_en) mem[ram_addr] <= ram_wdat;
            else           ram_dout <= mem[ram_addr];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (time %0t, required end before 200000)", $time);
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    task automatic clear_reqs();
        dmi_req_valid  = 1'b0;
        dmi_req_write  = 1'b0;
        dmi_req_addr   = 4'd0;
        dmi_req_wdata  = 32'h0;
        core_req_valid = 1'b0;
        core_req_write = 1'b0;
        core_req_addr  = 4'd0;
        core_req_wdata = 32'h0;
    endtask

    task automatic apply_reset();
        clear_reqs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        ram_dout = 32'h0;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        rst_n = 1'b0;
        clear_reqs();
        dmi_rsp_ready = 1'b1;

        // Reset state: both requesters pushing, nothing may be granted or strobed.
        dmi_req_valid  = 1'b1;
        core_req_valid = 1'b1;
        tick();
        samp();
        check_eq("rst_dmi_ready",  32'(dmi_req_ready),  32'h0);
        check_eq("rst_core_ready", 32'(core_req_ready), 32'h0);
        check_eq("rst_ram_cs",     32'(ram_cs),         32'h0);
        check_eq("rst_dmi_rspv",   32'(dmi_rsp_valid),  32'h0);
        check_eq("rst_core_rspv",  32'(core_rsp_valid), 32'h0);
        clear_reqs();
        tick();
        rst_n = 1'b1;

        // Out-of-range core read on the 12-deep instance.
        core_req_valid = 1'b1;
        core_req_write = 1'b0;
        core_req_addr  = 4'd13;
        samp();
        check_eq("oor_ready",  32'(core_req_ready_b), 32'h1);
        check_eq("oor_cs_acc", 32'(ram_cs_b),         32'h0);
        tick();
        core_req_valid = 1'b0;
        samp();
        check_eq("oor_rspv",  32'(core_rsp_valid_b), 32'h1);
        check_eq("oor_err",   32'(core_rsp_err_b),   32'h1);
        check_eq("oor_rdata", core_rsp_rdata_b,      32'h0);
        check_eq("oor_cs_r",  32'(ram_cs_b),         32'h0);
        tick();
        samp();
        check_eq("oor_pulse_end", 32'(core_rsp_valid_b), 32'h0);

        apply_reset();

        // DMI write then read-back of addr 3.
        dmi_req_valid = 1'b1;
        dmi_req_write = 1'b1;
        dmi_req_addr  = 4'd3;
        dmi_req_wdata = 32'hDEADBEEF;
        samp();
        check_eq("wr_cs",    32'(ram_cs),    32'h1);
        check_eq("wr_wren",  32'(ram_wr_en), 32'h1);
        check_eq("wr_addr",  32'(ram_addr),  32'h3);
        check_eq("wr_wdat",  ram_wdat,       32'hDEADBEEF);
        tick();
        clear_reqs();
        samp();
        check_eq("wr_rspv",  32'(dmi_rsp_valid), 32'h1);
        check_eq("wr_rdata", dmi_rsp_rdata,      32'h0);
        check_eq("wr_err",   32'(dmi_rsp_err),   32'h0);
        tick();
        dmi_req_valid = 1'b1;
        dmi_req_write = 1'b0;
        dmi_req_addr  = 4'd3;
        samp();
        check_eq("rd_ready", 32'(dmi_req_ready), 32'h1);
        check_eq("rd_cs",    32'(ram_cs),        32'h1);
        check_eq("rd_wren",  32'(ram_wr_en),     32'h0);
        tick();
        clear_reqs();
        samp();
        check_eq("rd_wait_rspv", 32'(dmi_rsp_valid), 32'h0);
        check_eq("rd_wait_cs",   32'(ram_cs),        32'h0);
        tick();
        samp();
        check_eq("rd_rspv",  32'(dmi_rsp_valid), 32'h1);
        check_eq("rd_rdata", dmi_rsp_rdata,      32'hDEADBEEF);
        check_eq("rd_err",   32'(dmi_rsp_err),   32'h0);
        tick();

        apply_reset();

        // Round-robin with both requesters writing every cycle from reset.
        dmi_req_valid  = 1'b1;
        dmi_req_write  = 1'b1;
        dmi_req_addr   = 4'd1;
        dmi_req_wdata  = 32'h11;
        core_req_valid = 1'b1;
        core_req_write = 1'b1;
        core_req_addr  = 4'd2;
        core_req_wdata = 32'h22;
        for (int k = 0; k < 4; k++) begin
            samp();
            check_eq($sformatf("arb%0d_core_ready", k), 32'(core_req_ready), 32'((k % 2) == 0));
            check_eq($sformatf("arb%0d_dmi_ready", k),  32'(dmi_req_ready),  32'((k % 2) == 1));
            tick();
            samp();
            check_eq($sformatf("arb%0d_core_rspv", k), 32'(core_rsp_valid), 32'((k % 2) == 0));
            check_eq($sformatf("arb%0d_dmi_rspv", k),  32'(dmi_rsp_valid),  32'((k % 2) == 1));
            tick();
        end
        clear_reqs();

        apply_reset();

        // DMI read of addr 3 held under response backpressure for 5 cycles.
        dmi_rsp_ready = 1'b0;
        dmi_req_valid = 1'b1;
        dmi_req_write = 1'b0;
        dmi_req_addr  = 4'd3;
        tick();
        core_req_valid = 1'b1;
        core_req_write = 1'b0;
        core_req_addr  = 4'd2;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            samp();
            check_eq($sformatf("bp%0d_rspv", i),       32'(dmi_rsp_valid),  32'h1);
            check_eq($sformatf("bp%0d_rdata", i),      dmi_rsp_rdata,       32'hDEADBEEF);
            check_eq($sformatf("bp%0d_err", i),        32'(dmi_rsp_err),    32'h0);
            check_eq($sformatf("bp%0d_dmi_ready", i),  32'(dmi_req_ready),  32'h0);
            check_eq($sformatf("bp%0d_core_ready", i), 32'(core_req_ready), 32'h0);
            check_eq($sformatf("bp%0d_cs", i),         32'(ram_cs),         32'h0);
            tick();
        end
        dmi_rsp_ready = 1'b1;
        samp();
        check_eq("bp_hs_rspv", 32'(dmi_rsp_valid), 32'h1);
        tick();
        samp();
        check_eq("bp_idle_rspv",       32'(dmi_rsp_valid),  32'h0);
        check_eq("bp_idle_core_ready", 32'(core_req_ready), 32'h1);
        check_eq("bp_idle_dmi_ready",  32'(dmi_req_ready),  32'h0);
        clear_reqs();
        tick();

        apply_reset();

        // Reset during RD_WAIT, then DMI write 15 and core read-back.
        core_req_valid = 1'b1;
        core_req_write = 1'b0;
        core_req_addr  = 4'd3;
        tick();
        clear_reqs();
        rst_n = 1'b0;
        dmi_req_valid = 1'b1;
        dmi_req_write = 1'b1;
        dmi_req_addr  = 4'd15;
        dmi_req_wdata = 32'h12345678;
        samp();
        check_eq("mid_rst_core_rspv", 32'(core_rsp_valid), 32'h0);
        check_eq("mid_rst_dmi_ready", 32'(dmi_req_ready),  32'h0);
        check_eq("mid_rst_cs",        32'(ram_cs),         32'h0);
        check_eq("mid_rst_addr",      32'(ram_addr),       32'h0);
        check_eq("mid_rst_wdat",      ram_wdat,            32'h0);
        tick();
        rst_n = 1'b1;
        samp();
        check_eq("rel_dmi_ready", 32'(dmi_req_ready),  32'h1);
        check_eq("rel_cs",        32'(ram_cs),         32'h1);
        check_eq("rel_wren",      32'(ram_wr_en),      32'h1);
        check_eq("rel_addr",      32'(ram_addr),       32'hF);
        check_eq("rel_core_rspv", 32'(core_rsp_valid), 32'h0);
        tick();
        clear_reqs();
        samp();
        check_eq("w15_rspv",      32'(dmi_rsp_valid),  32'h1);
        check_eq("w15_core_rspv", 32'(core_rsp_valid), 32'h0);
        tick();
        core_req_valid = 1'b1;
        core_req_write = 1'b0;
        core_req_addr  = 4'd15;
        samp();
        check_eq("r15_ready", 32'(core_req_ready), 32'h1);
        check_eq("r15_cs",    32'(ram_cs),         32'h1);
        tick();
        clear_reqs();
        samp();
        check_eq("r15_wait_rspv", 32'(core_rsp_valid), 32'h0);
        tick();
        samp();
        check_eq("r15_rspv",  32'(core_rsp_valid), 32'h1);
        check_eq("r15_rdata", core_rsp_rdata,      32'h12345678);
        check_eq("r15_err",   32'(core_rsp_err),   32'h0);
        tick();
        samp();
        check_eq("r15_pulse_end", 32'(core_rsp_valid), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
